// File: rtl/mpt64_table_responder.sv
// Memory-side responder for the MPT page-table walker: serves req/gnt/rvalid
// reads from an internal 64-bit table with programmable grant/data latency.
module mpt64_table_responder #(
  parameter int          DEPTH        = 256,
  parameter logic [55:0] BASE_ADDR    = 56'h0,
  parameter int          GNT_DELAY    = 0,
  parameter int          RVALID_DELAY = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic [55:0]              addr_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [63:0]              rdata_o,
  output logic                     err_o,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  logic [63:0]              wr_data_i,
  output logic                     busy_o
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [55:0] r_addr;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] r_mem [DEPTH];

  logic          w_gnt, w_rvalid, w_latch;
  logic [55:0]   w_off;
  logic          w_fault;
  logic [IW-1:0] w_idx;
  logic [63:0]   w_word;

  // Decode works on the address latched in IDLE, never on the live addr_i.
  assign w_off   = r_addr - BASE_ADDR;
  assign w_fault = (r_addr < BASE_ADDR) || (w_off[2:0] != 3'b000) ||
                   (w_off[55:3] >= 53'(DEPTH));
  assign w_idx   = w_off[IW+2:3];
  // A backdoor write landing on the word being granted wins (write-first).
  assign w_word  = (wr_en_i && (wr_idx_i == w_idx)) ? wr_data_i : r_mem[w_idx];

  // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt       = 1'b0;
    w_rvalid    = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = 4'(GNT_DELAY);
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!req_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_gnt       = 1'b1;
          w_cnt_nxt   = 4'(RVALID_DELAY);
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_rvalid    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values and simulation matches hardware.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 56'h0;
      r_rdata <= 64'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) r_addr <= addr_i;
      if (w_gnt) begin
        r_rdata <= w_fault ? 64'h0 : w_word;
        r_err   <= w_fault;
      end
    end
  end

  // NOTE: the table is deliberately not reset; contents must survive rst_ni and a reset would forbid RAM inference.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[wr_idx_i] <= wr_data_i;
  end

  // Strobes are suppressed while reset is asserted so an interrupted transfer never emits them.
  assign gnt_o    = w_gnt & rst_ni;
  assign rvalid_o = w_rvalid & rst_ni;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign busy_o   = (r_state != S_IDLE);

endmodule

// File: doc/mpt64_table_responder.md
# mpt64_table_responder

Memory-side responder for the 64-bit MPT page-table walker. It answers the walker's req/gnt/rvalid read handshake out of an internal array of 64-bit table words, such as MMPT root, MPTL3, MPTL2 and MPTL1 entries. Grant and read-data latency are programmable. A backdoor write port lets a bench or boot agent preload and modify tables. It serves as the walker's memory model in block-level verification and as a tightly-coupled table RAM in integration.

## Interface
Parameters:
- DEPTH, 256: number of 64-bit table words; power of two, at least 2.
- BASE_ADDR, 56'h0: physical byte address of word 0; 8-byte aligned.
- GNT_DELAY, 0: extra cycles in GRANT before gnt_o; range 0..15.
- RVALID_DELAY, 0: extra cycles between gnt and rvalid; range 0..15.

Ports:
- clk_i, input, 1: single clock; all logic is on the rising edge.
- rst_ni, input, 1: reset, synchronous, active-low.
- req_i, input, 1: walker read request; held until gnt_o or withdrawn.
- addr_i, input, 56: physical byte address of the requested entry (PLEN = 56).
- gnt_o, output, 1: request accepted; one-cycle pulse.
- rvalid_o, output, 1: rdata_o and err_o valid; one-cycle pulse.
- rdata_o, output, 64: table word read.
- err_o, output, 1: access fault for the current response; qualified by rvalid_o.
- wr_en_i, input, 1: backdoor write enable.
- wr_idx_i, input, $clog2(DEPTH): backdoor word index.
- wr_data_i, input, 64: backdoor write data.
- busy_o, output, 1: high whenever state != IDLE.

## Operation
- States: IDLE, GRANT, RESP. Internal registers: 4-bit cnt, 56-bit latched address, captured data and error.
- IDLE
  - gnt_o=0, rvalid_o=0.
  - If req_i=1: latch addr_i, set cnt<=GNT_DELAY, go to GRANT.
- GRANT
  - If req_i=0 (walker flush/abort): go to IDLE. No gnt, no response.
  - Else if cnt!=0: cnt<=cnt-1.
  - Else: gnt_o=1 (combinational). Capture the response, set cnt<=RVALID_DELAY, go to RESP.
- RESP
  - req_i is ignored; gnt_o stays 0.
  - If cnt!=0: cnt<=cnt-1.
  - Else: rvalid_o=1 (combinational), go to IDLE.
- Address decode is done at the gnt cycle on the latched address:
  - off = addr - BASE_ADDR, computed 56-bit unsigned.
  - Fault if addr < BASE_ADDR, or off[2:0] != 0, or off[55:3] >= DEPTH.
  - On fault: rdata<=64'h0, err<=1.
  - Else: rdata<=mem[off[55:3]], err<=0.
- rdata_o and err_o are registered.
  - They update only at the gnt edge.
  - They hold their value until the next gnt.
- Backdoor write: if wr_en_i=1, mem[wr_idx_i]<=wr_data_i at the clock edge. This works in any state.
- Write/read collision: if the gnt cycle reads the same index wr_idx_i with wr_en_i=1, the captured rdata is wr_data_i (write-first forwarding).
- addr_i changes after latching are ignored. The response always corresponds to the address sampled in IDLE.
- Exactly one request is outstanding. No pipelining of a second request.

## Timing
- Reset values: state=IDLE, cnt=0, gnt_o=0, rvalid_o=0, rdata_o=64'h0, err_o=0, busy_o=0.
- mem is not reset; contents survive rst_ni.
- Reset mid-transaction: state goes to IDLE on the next edge. Any pending gnt or rvalid is dropped and never emitted.
- With req_i first high in cycle T and held:
  - gnt_o is high in cycle T+1+GNT_DELAY.
  - rvalid_o is high in cycle T+2+GNT_DELAY+RVALID_DELAY.
- Minimum turnaround: the next request can be latched in the cycle after rvalid_o (IDLE). A req_i held through the rvalid cycle is latched in the following cycle.
- gnt_o and rvalid_o are never high in the same cycle.
- Each gnt_o is followed by exactly one rvalid_o unless reset intervenes.

## Test plan
- Basic read, defaults:
  - Backdoor write mem[3]=64'h0000_0001_0000_0ABC.
  - req_i with addr_i=56'h18 at cycle T.
  - Expect gnt_o at T+1, rvalid_o at T+2, rdata_o=64'h0000_0001_0000_0ABC, err_o=0.
- Latency sweep, GNT_DELAY=3, RVALID_DELAY=5:
  - Expect gnt_o at T+4 and rvalid_o at T+10.
  - busy_o high from T+1 through T+10.
- Faults, BASE_ADDR=56'h1000, DEPTH=256:
  - addr_i=56'h1004 (misaligned): err_o=1, rdata_o=0.
  - addr_i=56'h1800 (index 256): err_o=1, rdata_o=0.
  - addr_i=56'h0FF8 (below base): err_o=1, rdata_o=0.
- Abort, GNT_DELAY=4:
  - Drop req_i in cycle T+2.
  - Expect no gnt_o and no rvalid_o; state is IDLE at T+3.
  - A new req at T+5 is served normally.
- Collision:
  - mem[7]=64'hAAAA, then request addr_i=56'h38.
  - In the gnt cycle, write wr_idx_i=7, wr_data_i=64'h5555.
  - Expect rdata_o=64'h5555.
- Reset mid-op, RVALID_DELAY=6:
  - Assert rst_ni=0 for one cycle two cycles after gnt_o.
  - Expect no rvalid_o, all outputs at reset values, and mem contents intact on a later read.
